// File: rtl/timer0_controller_if.sv
// rtl/timer0_controller_if.sv - Timer0 write port, interrupt handshake and observation signals
interface timer0_controller_if #(
    parameter int counterWidth = 8
);
    logic                    wr_en;
    logic [1:0]              wr_addr;
    logic [7:0]              wr_data;
    logic                    irq_ack;
    logic [counterWidth-1:0] tcnt_out;
    logic                    ocf_out;
    logic                    tov_out;
    logic                    irq_out;
    logic                    tick_out;

    // CPU / interrupt-controller side
    modport master (
        output wr_en, wr_addr, wr_data, irq_ack,
        input  tcnt_out, ocf_out, tov_out, irq_out, tick_out
    );

    // Timer side
    modport slave (
        input  wr_en, wr_addr, wr_data, irq_ack,
        output tcnt_out, ocf_out, tov_out, irq_out, tick_out
    );
endinterface

// File: rtl/timer0_controller.sv
// rtl/timer0_controller.sv - Prescaled 8-bit Timer0 with compare/overflow flags and irq handshake
module timer0_controller #(
    parameter int counterWidth   = 8,
    parameter int prescalerWidth = 10
) (
    input  logic               clock50,
    input  logic               MR_n,
    timer0_controller_if.slave bus
);
    localparam logic [counterWidth-1:0]   C_ZERO = '0;
    localparam logic [counterWidth-1:0]   C_ONE  = counterWidth'(1);
    localparam logic [prescalerWidth-1:0] P_ZERO = '0;
    localparam logic [prescalerWidth-1:0] P_ONE  = prescalerWidth'(1);

    logic [5:0]                r_tccr;
    logic [prescalerWidth-1:0] r_presc;
    logic [counterWidth-1:0]   r_tcnt;
    logic [counterWidth-1:0]   r_ocr;
    logic                      r_ocf;
    logic                      r_tov;

    logic [2:0]              w_cs;
    logic                    w_ctc;
    logic                    w_ocie;
    logic                    w_toie;
    logic                    w_tick;
    logic                    w_wr_tccr;
    logic                    w_wr_tcnt;
    logic                    w_wr_ocr;
    logic                    w_wr_tifr;
    logic                    w_match;
    logic                    w_at_max;
    logic                    w_count_tick;
    logic                    w_set_ocf;
    logic                    w_set_tov;
    logic                    w_ocf_irq;
    logic                    w_tov_irq;
    logic                    w_clr_ocf;
    logic                    w_clr_tov;
    logic [counterWidth-1:0] w_wr_value;

    assign w_cs   = r_tccr[2:0];
    assign w_ctc  = r_tccr[3];
    assign w_ocie = r_tccr[4];
    assign w_toie = r_tccr[5];

    assign w_wr_tccr  = bus.wr_en && (bus.wr_addr == 2'd0);
    assign w_wr_tcnt  = bus.wr_en && (bus.wr_addr == 2'd1);
    assign w_wr_ocr   = bus.wr_en && (bus.wr_addr == 2'd2);
    assign w_wr_tifr  = bus.wr_en && (bus.wr_addr == 2'd3);
    assign w_wr_value = counterWidth'(bus.wr_data);

    // Tick fires on the last prescaler state of each selected period
    always_comb begin
        w_tick = 1'b0;
        case (w_cs)
            3'd1:    w_tick = 1'b1;
            3'd2:    w_tick = &r_presc[2:0];
            3'd3:    w_tick = &r_presc[5:0];
            3'd4:    w_tick = &r_presc[7:0];
            3'd5:    w_tick = &r_presc[9:0];
            default: w_tick = 1'b0;
        endcase
    end

    // A TCNT write wins over the tick, so that cycle neither counts nor flags
    assign w_match      = (r_tcnt == r_ocr);
    assign w_at_max     = &r_tcnt;
    assign w_count_tick = w_tick && !w_wr_tcnt;
    assign w_set_ocf    = w_count_tick && w_match;
    assign w_set_tov    = w_count_tick && w_at_max;

    // Ack services the compare interrupt first, overflow only when compare is not pending
    assign w_ocf_irq = r_ocf && w_ocie;
    assign w_tov_irq = r_tov && w_toie;
    assign w_clr_ocf = (w_wr_tifr && bus.wr_data[0]) || (bus.irq_ack && w_ocf_irq);
    assign w_clr_tov = (w_wr_tifr && bus.wr_data[1]) || (bus.irq_ack && w_tov_irq && !w_ocf_irq);

    // Configuration registers
    always_ff @(posedge clock50 or negedge MR_n) begin
        if (!MR_n) begin
            r_tccr <= 6'd0;
            r_ocr  <= C_ZERO;
        end else begin
            if (w_wr_tccr) r_tccr <= bus.wr_data[5:0];
            if (w_wr_ocr)  r_ocr  <= w_wr_value;
        end
    end

    // Free-running prescaler, zeroed while stopped or when a stop is written
    always_ff @(posedge clock50 or negedge MR_n) begin
        if (!MR_n) begin
            r_presc <= P_ZERO;
        end else if ((w_wr_tccr && (bus.wr_data[2:0] == 3'd0)) || (w_cs == 3'd0)) begin
            r_presc <= P_ZERO;
        end else begin
            r_presc <= r_presc + P_ONE;
        end
    end

    // Count register: load, CTC restart on match, or plain increment with wrap
    always_ff @(posedge clock50 or negedge MR_n) begin
        if (!MR_n) begin
            r_tcnt <= C_ZERO;
        end else if (w_wr_tcnt) begin
            r_tcnt <= w_wr_value;
        end else if (w_tick) begin
            if (w_ctc && w_match) r_tcnt <= C_ZERO;
            else                  r_tcnt <= r_tcnt + C_ONE;
        end
    end

    // Flags: a set in the same cycle as a clear wins
    always_ff @(posedge clock50 or negedge MR_n) begin
        if (!MR_n) begin
            r_ocf <= 1'b0;
            r_tov <= 1'b0;
        end else begin
            if (w_set_ocf)      r_ocf <= 1'b1;
            else if (w_clr_ocf) r_ocf <= 1'b0;
            if (w_set_tov)      r_tov <= 1'b1;
            else if (w_clr_tov) r_tov <= 1'b0;
        end
    end

    assign bus.tcnt_out = r_tcnt;
    assign bus.ocf_out  = r_ocf;
    assign bus.tov_out  = r_tov;
    assign bus.irq_out  = w_ocf_irq || w_tov_irq;
    assign bus.tick_out = w_tick;
endmodule

// File: tb/tb_timer0_controller.sv
// tb/tb_timer0_controller.sv - Self-checking bench for timer0_controller against a behavioural model
module tb_timer0_controller;
    logic clock50 = 1'b0;
    logic MR_n    = 1'b0;

    timer0_controller_if #(.counterWidth(8)) bus ();

    timer0_controller #(.counterWidth(8), .prescalerWidth(10)) dut (
        .clock50 (clock50),
        .MR_n    (MR_n),
        .bus     (bus.slave)
    );

    always #10 clock50 = ~clock50;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_cs, m_pcount, m_cnt, m_ocr;
    bit m_ctc, m_ocie, m_toie, m_ocf, m_tov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cs = 0; m_pcount = 0; m_cnt = 0; m_ocr = 0;
        m_ctc = 0; m_ocie = 0; m_toie = 0; m_ocf = 0; m_tov = 0;
    endtask

    function automatic bit model_tick();
        int period;
        case (m_cs)
            1: period = 1;
            2: period = 8;
            3: period = 64;
            4: period = 256;
            5: period = 1024;
            default: return 1'b0;
        endcase
        return (m_pcount % period) == (period - 1);
    endfunction

    function automatic bit model_irq();
        return (m_ocf && m_ocie) || (m_tov && m_toie);
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance model and clock
    task automatic do_cycle(input bit we, input int a, input logic [7:0] d, input bit ack);
        bit tick, tw, tifr, so, st, co, ct, irq_o, irq_t;
        bus.wr_en   = we;
        bus.wr_addr = a[1:0];
        bus.wr_data = d;
        bus.irq_ack = ack;
        tick = model_tick();
        chk("tcnt", {24'd0, bus.tcnt_out}, m_cnt);
        chk("ocf",  {31'd0, bus.ocf_out},  {31'd0, m_ocf});
        chk("tov",  {31'd0, bus.tov_out},  {31'd0, m_tov});
        chk("irq",  {31'd0, bus.irq_out},  {31'd0, model_irq()});
        chk("tick", {31'd0, bus.tick_out}, {31'd0, tick});
        tw    = we && (a == 1);
        tifr  = we && (a == 3);
        irq_o = m_ocf && m_ocie;
        irq_t = m_tov && m_toie;
        so    = tick && !tw && (m_cnt == m_ocr);
        st    = tick && !tw && (m_cnt == 255);
        co    = (tifr && d[0]) || (ack && irq_o);
        ct    = (tifr && d[1]) || (ack && !irq_o && irq_t);
        if (tw)        m_cnt = int'(d);
        else if (tick) m_cnt = (m_ctc && m_cnt == m_ocr) ? 0 : (m_cnt + 1) % 256;
        m_ocf = so ? 1'b1 : (co ? 1'b0 : m_ocf);
        m_tov = st ? 1'b1 : (ct ? 1'b0 : m_tov);
        if ((we && a == 0 && d[2:0] == 3'd0) || m_cs == 0) m_pcount = 0;
        else                                                m_pcount = (m_pcount + 1) % 1024;
        if (we && a == 0) begin
            m_cs = int'(d[2:0]); m_ctc = d[3]; m_ocie = d[4]; m_toie = d[5];
        end
        if (we && a == 2) m_ocr = int'(d);
        @(negedge clock50);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 8'h00, 0);
    endtask

    initial begin
        int first_tick;
        bit saw_tov;
        bit ack;
        int r;
        logic [7:0] d;

        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.irq_ack = 0;
        model_reset();
        repeat (2) @(negedge clock50);
        MR_n = 1'b1;
        chk("rst_tcnt", {24'd0, bus.tcnt_out}, 32'd0);
        chk("rst_irq",  {31'd0, bus.irq_out},  32'd0);
        chk("rst_tick", {31'd0, bus.tick_out}, 32'd0);

        // Asynchronous reset in the middle of a count
        do_cycle(1, 0, 8'h01, 0);
        do_cycle(1, 1, 8'h40, 0);
        idle(3);
        #3 MR_n = 1'b0;
        #1;
        chk("arst_tcnt", {24'd0, bus.tcnt_out}, 32'd0);
        chk("arst_ocf",  {31'd0, bus.ocf_out},  32'd0);
        chk("arst_tov",  {31'd0, bus.tov_out},  32'd0);
        chk("arst_irq",  {31'd0, bus.irq_out},  32'd0);
        chk("arst_tick", {31'd0, bus.tick_out}, 32'd0);
        model_reset();
        @(negedge clock50);
        MR_n = 1'b1;
        idle(5);
        chk("arst_hold", {24'd0, bus.tcnt_out}, 32'd0);

        // Normal-mode overflow with acknowledge
        do_cycle(1, 0, 8'h21, 0);
        do_cycle(1, 1, 8'hFE, 0);
        idle(2);
        chk("ovf_tcnt", {24'd0, bus.tcnt_out}, 32'd0);
        chk("ovf_tov",  {31'd0, bus.tov_out},  32'd1);
        chk("ovf_irq",  {31'd0, bus.irq_out},  32'd1);
        do_cycle(0, 0, 8'h00, 1);
        chk("ack_tov", {31'd0, bus.tov_out}, 32'd0);
        chk("ack_irq", {31'd0, bus.irq_out}, 32'd0);

        // CTC mode, period 6
        do_cycle(1, 0, 8'h00, 0);
        do_cycle(1, 3, 8'h03, 0);
        do_cycle(1, 2, 8'h05, 0);
        do_cycle(1, 1, 8'h00, 0);
        do_cycle(1, 0, 8'h19, 0);
        saw_tov = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.tov_out) saw_tov = 1;
            idle(1);
        end
        chk("ctc_no_tov", {31'd0, saw_tov}, 32'd0);
        chk("ctc_ocf",    {31'd0, bus.ocf_out}, 32'd1);

        // Prescaler CS=3 from a fresh reset
        MR_n = 1'b0;
        model_reset();
        @(negedge clock50);
        MR_n = 1'b1;
        do_cycle(1, 0, 8'h03, 0);
        first_tick = -1;
        for (int i = 0; i < 256; i++) begin
            if (bus.tick_out && first_tick < 0) first_tick = i;
            idle(1);
        end
        chk("presc_first", first_tick, 32'd63);
        chk("presc_tcnt",  {24'd0, bus.tcnt_out}, 32'd4);
        do_cycle(1, 0, 8'h00, 0);
        idle(10);
        chk("stop_hold", {24'd0, bus.tcnt_out}, 32'd4);

        // Collisions: TCNT write on a tick, TIFR clear when TOV sets
        do_cycle(1, 0, 8'h01, 0);
        do_cycle(1, 3, 8'h03, 0);
        do_cycle(1, 1, 8'hFF, 0);
        do_cycle(1, 1, 8'h10, 0);
        chk("coll_tcnt", {24'd0, bus.tcnt_out}, 32'h10);
        chk("coll_tov",  {31'd0, bus.tov_out},  32'd0);
        do_cycle(1, 1, 8'hFF, 0);
        do_cycle(1, 3, 8'h02, 0);
        chk("clr_vs_set", {31'd0, bus.tov_out}, 32'd1);

        // Ack priority: compare first, then overflow
        do_cycle(1, 0, 8'h30, 0);
        do_cycle(1, 3, 8'h03, 0);
        do_cycle(1, 2, 8'hFF, 0);
        do_cycle(1, 1, 8'hFF, 0);
        do_cycle(1, 0, 8'h31, 0);
        do_cycle(1, 0, 8'h30, 0);
        chk("both_ocf", {31'd0, bus.ocf_out}, 32'd1);
        chk("both_tov", {31'd0, bus.tov_out}, 32'd1);
        do_cycle(0, 0, 8'h00, 1);
        chk("ack1_ocf", {31'd0, bus.ocf_out}, 32'd0);
        chk("ack1_tov", {31'd0, bus.tov_out}, 32'd1);
        chk("ack1_irq", {31'd0, bus.irq_out}, 32'd1);
        do_cycle(0, 0, 8'h00, 1);
        chk("ack2_tov", {31'd0, bus.tov_out}, 32'd0);
        chk("ack2_irq", {31'd0, bus.irq_out}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r   = int'($urandom_range(0, 99));
            d   = 8'($urandom);
            ack = ($urandom_range(0, 4) == 0);
            if (r < 80) begin
                do_cycle(0, 0, d, ack);
            end else if (r < 85) begin
                d[2:0] = 3'($urandom_range(0, 3));
                do_cycle(1, 0, d, ack);
            end else if (r < 90) begin
                if (d[0]) d = 8'hF8 | d;
                do_cycle(1, 1, d, ack);
            end else if (r < 95) begin
                do_cycle(1, 2, d, ack);
            end else begin
                do_cycle(1, 3, d, ack);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/timer0_controller.md
# timer0_controller

Prescaled 8-bit timer/counter controller for the ATMega32A emulator's Timer0 peripheral. It owns the prescaler, the count register, the compare register and the flag/interrupt logic. It sequences the count on selected prescaler ticks and raises overflow and compare-match interrupts toward the interrupt controller with a request/acknowledge handshake. The CPU configures it through a small write port.

## Interface
- counterWidth, 8, width of count and compare registers
- prescalerWidth, 10, width of the free-running prescaler (must be ≥10)

- clock50  input  1  system clock, all state on rising edge
- MR_n  input  1  master reset, asynchronous, active-low
- wr_en  input  1  register write strobe, one cycle per write
- wr_addr  input  2  0=TCCR, 1=TCNT, 2=OCR, 3=TIFR clear
- wr_data  input  8  write data
- irq_ack  input  1  one-cycle acknowledge from interrupt controller
- tcnt_out  output  counterWidth  current count
- ocf_out  output  1  output-compare flag
- tov_out  output  1  overflow flag
- irq_out  output  1  interrupt request
- tick_out  output  1  prescaled count-enable pulse (debug/observability)

## Operation
- TCCR bits: [2:0] CS clock select, [3] CTC mode, [4] OCIE, [5] TOIE, [7:6] ignored (read as 0 internally).
- Prescaler: free-running, increments every cycle while CS≠0, held at 0 while CS=0.
- Tick selection: CS=1 every cycle; CS=2 when prescaler[2:0] all ones; CS=3 when [5:0] all ones; CS=4 when [7:0] all ones; CS=5 when [9:0] all ones; CS=0,6,7 no tick (stopped).
- On tick, normal mode (CTC=0): TCNT increments. The step from 2^counterWidth−1 to 0 sets TOV. If the pre-increment TCNT==OCR, OCF is set.
- On tick, CTC mode: if TCNT==OCR, TCNT goes to 0 and OCF is set. Otherwise TCNT increments, with wrap and TOV as in normal mode. With OCR=max, both OCF and TOV are set and the next value is 0.
- TCNT write: loads wr_data and overrides any tick in the same cycle. No compare or overflow flag is set in that cycle.
- OCR/TCCR writes take effect from the next cycle. A CS change does not clear the prescaler unless the new CS is 0.
- TIFR clear: writing 1 to wr_data[0] clears OCF, writing 1 to wr_data[1] clears TOV. Writing 0 leaves the flag unchanged.
- Flag priority: a set and a clear (TIFR write or ack) in the same cycle resolve to set, so no event is lost.
- irq_out = (OCF & OCIE) | (TOV & TOIE), combinational from registered flags.
- irq_ack: clears OCF if OCF & OCIE, otherwise clears TOV if TOV & TOIE. Ack with irq_out low is ignored.
- Arithmetic modulo 2^counterWidth. The compare is full-width equality.

## Timing
- Reset (MR_n low, any time, asynchronous): prescaler, TCCR, TCNT, OCR, OCF, TOV all 0. Outputs tcnt_out=0, ocf_out=0, tov_out=0, irq_out=0, tick_out=0. Reset mid-count discards all state immediately.
- Tick in cycle n: tcnt_out and flags update at the edge ending cycle n. irq_out rises in cycle n+1.
- tick_out is a single-cycle pulse, asserted in the cycle the tick is consumed.
- CS=2 from prescaler 0: first tick in cycle 7, then every 8 cycles. CS=5: every 1024 cycles.
- Write latency: one edge for every register.
- irq_ack in cycle n: the flag is low and irq_out re-evaluates in cycle n+1.

## Test plan
- Reset: assert MR_n mid-count with CS=1, TCNT=0x40 -> all outputs 0 asynchronously. After release, TCNT holds 0 until a tick.
- Normal overflow: CS=1, TOIE=1, TCNT=0xFE -> TCNT 0xFF, then 0x00 with tov_out=1 and irq_out=1 one cycle later. irq_ack -> tov_out=0, irq_out=0.
- CTC: CS=1, CTC=1, OCR=0x05, OCIE=1 -> TCNT cycles 0..5,0 (period 6). ocf_out sets on each 5->0 step. tov_out never sets.
- Prescaler: CS=3 from reset -> tick_out every 64 cycles, first at cycle 63. TCNT=4 after 256 cycles. Switching CS to 0 holds TCNT and zeroes the prescaler.
- Collisions: TCNT write 0x10 on a tick cycle -> TCNT=0x10 and no flag. TIFR clear on the cycle TOV sets -> tov_out=1.
- Ack priority: OCF and TOV both set with both enables on -> first ack clears OCF only, irq_out stays 1. Second ack clears TOV, irq_out=0.
